// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: 25xx-style SPI EEPROM device model.
// Oversamples cs/sclk/mosi on clk and serves a small register-file memory.
module spi_eeprom_responder #(
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_BYTES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic wel,
  output logic busy
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ_DATA,
    WRITE_DATA,
    RDSR,
    IGNORE
  } state_t;

  state_t state, state_next;

  logic [2:0]    cs_q;
  logic [2:0]    sclk_q;
  logic [1:0]    mosi_q;
  logic          cs_fall, cs_rise;
  logic          sclk_rise, sclk_fall;
  logic          cs_low, din;
  logic          bit_last, addr_last;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    rx;
  logic [7:0]    rx_byte;
  logic [7:0]    tx;
  logic [AW-1:0] addr;
  logic [AW:0]   addr_sh;
  logic          is_write;
  logic          wrote;
  logic          miso_q;
  logic          wel_q;
  logic [7:0]    mem [MEM_DEPTH];

  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign cs_low    = ~cs_q[1];
  assign din       = mosi_q[1];
  assign rx_byte   = {rx[6:0], din};
  assign addr_sh   = {addr, din};
  assign bit_last  = (bit_cnt == 3'd7);
  assign addr_last = (byte_cnt == 2'(ADDR_BYTES - 1));

  assign miso    = miso_q;
  assign miso_oe = (state == READ_DATA) || (state == RDSR);
  assign wel     = wel_q;
  assign busy    = (state != IDLE);

  // Synchronisers are left free-running so a reset with cs low sees no edge.
  always_ff @(posedge clk) begin
    cs_q   <= {cs_q[1:0], cs};
    sclk_q <= {sclk_q[1:0], sclk};
    mosi_q <= {mosi_q[0], mosi};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: cs framing first, then opcode/address completion.
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else if (cs_fall) begin
      state_next = CMD;
    end else if (cs_low && sclk_rise && bit_last) begin
      unique case (state)
        CMD: begin
          case (rx_byte)
            8'h03:   state_next = ADDR;
            8'h02:   state_next = wel_q ? ADDR : IGNORE;
            8'h05:   state_next = RDSR;
            default: state_next = IGNORE;
          endcase
        end
        ADDR: begin
          if (addr_last)
            state_next = is_write ? WRITE_DATA : READ_DATA;
        end
        default: state_next = state;
      endcase
    end
  end

  // Datapath: shift in on sclk rise, shift out on sclk fall, memory and wel.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx       <= '0;
      tx       <= '0;
      addr     <= '0;
      is_write <= 1'b0;
      wrote    <= 1'b0;
      miso_q   <= 1'b0;
      wel_q    <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= 8'h00;
    end else if (cs_rise) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      miso_q   <= 1'b0;
      if (state == WRITE_DATA && wrote)
        wel_q <= 1'b0;
    end else if (cs_fall) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      addr     <= '0;
      wrote    <= 1'b0;
      miso_q   <= 1'b0;
    end else if (cs_low && state != IDLE) begin
      if (sclk_rise) begin
        if (state == CMD || state == ADDR || state == WRITE_DATA) begin
          rx      <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        unique case (state)
          CMD: begin
            if (bit_last) begin
              is_write <= (rx_byte == 8'h02);
              if (rx_byte == 8'h06) wel_q <= 1'b1;
              if (rx_byte == 8'h04) wel_q <= 1'b0;
            end
          end
          ADDR: begin
            addr <= addr_sh[AW-1:0];
            if (bit_last) byte_cnt <= byte_cnt + 2'd1;
          end
          WRITE_DATA: begin
            if (bit_last) begin
              mem[addr] <= rx_byte;
              addr      <= addr + AW'(1);
              wrote     <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (sclk_fall && (state == READ_DATA || state == RDSR)) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd0) begin
          if (state == READ_DATA) begin
            miso_q <= mem[addr][7];
            tx     <= {mem[addr][6:0], 1'b0};
            addr   <= addr + AW'(1);
          end else begin
            miso_q <= 1'b0;
            tx     <= {5'b0, wel_q, 2'b0};
          end
        end else begin
          miso_q <= tx[7];
          tx     <= {tx[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// tb_spi_eeprom_responder: directed bench for the SPI EEPROM responder.
// Drives mode-0 transfers with sclk at 1/8 of clk and checks miso bytes.
module tb_spi_eeprom_responder;

  logic clk = 1'b0;
  logic reset;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic wel;
  logic busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] d;
  logic       oe;

  spi_eeprom_responder #(
    .MEM_DEPTH(16),
    .ADDR_BYTES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .miso_oe(miso_oe),
    .wel(wel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] t, output logic [7:0] r,
                      output logic oe_any);
    r = 8'h00;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      mosi = t[i];
      #40;
      r[i] = miso;
      oe_any = oe_any | miso_oe;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] t);
    logic [7:0] r;
    logic o;
    xfer(t, r, o);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    send(op);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #40;
    cs = 1'b1;
    #80;
  endtask

  task automatic one_cmd(input logic [7:0] op);
    cs_low();
    send(op);
    cs_high();
  endtask

  initial begin
    reset = 1'b1;
    cs    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    #50;
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_wel", wel, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #40;

    // Read of erased memory, busy framing.
    cs_low();
    check("busy_on", busy, 1);
    hdr(8'h03, 24'h000000);
    xfer(8'h00, d, oe);
    check("rd0_b0", d, 8'h00);
    check("rd0_oe", oe, 1);
    xfer(8'h00, d, oe);
    check("rd0_b1", d, 8'h00);
    #40;
    cs = 1'b1;
    #20;
    check("busy_2clk", busy, 1);
    #10;
    check("busy_3clk", busy, 0);
    check("oe_off", miso_oe, 0);
    check("miso_off", miso, 0);
    #80;

    // Write without WREN is ignored.
    cs_low();
    hdr(8'h02, 24'h000005);
    send(8'h5A);
    cs_high();
    check("nowren_wel", wel, 0);
    cs_low();
    hdr(8'h03, 24'h000005);
    xfer(8'h00, d, oe);
    check("nowren_rd", d, 8'h00);
    cs_high();

    // WREN, two-byte write, status, readback.
    one_cmd(8'h06);
    check("wren_wel", wel, 1);
    cs_low();
    hdr(8'h02, 24'h000003);
    send(8'hA5);
    send(8'h3C);
    check("wr_wel_in", wel, 1);
    cs_high();
    check("wr_wel_clr", wel, 0);
    cs_low();
    send(8'h05);
    xfer(8'h00, d, oe);
    check("rdsr_after_wr", d, 8'h00);
    check("rdsr_oe", oe, 1);
    cs_high();
    cs_low();
    hdr(8'h03, 24'h000003);
    xfer(8'h00, d, oe);
    check("rd3_b0", d, 8'hA5);
    xfer(8'h00, d, oe);
    check("rd3_b1", d, 8'h3C);
    cs_high();

    // Wrap-around from the top address, high address bits ignored.
    one_cmd(8'h06);
    cs_low();
    hdr(8'h02, 24'h00000F);
    send(8'h11);
    cs_high();
    one_cmd(8'h06);
    cs_low();
    hdr(8'h02, 24'h000000);
    send(8'h22);
    cs_high();
    cs_low();
    hdr(8'h03, 24'h00000F);
    xfer(8'h00, d, oe);
    check("wrap_b0", d, 8'h11);
    xfer(8'h00, d, oe);
    check("wrap_b1", d, 8'h22);
    xfer(8'h00, d, oe);
    check("wrap_b2", d, 8'h00);
    cs_high();
    cs_low();
    hdr(8'h03, 24'h0000FF);
    xfer(8'h00, d, oe);
    check("alias_ff", d, 8'h11);
    cs_high();

    // Status register, WRDI, unknown opcode.
    one_cmd(8'h06);
    cs_low();
    send(8'h05);
    xfer(8'h00, d, oe);
    check("rdsr_wel1", d, 8'h02);
    xfer(8'h00, d, oe);
    check("rdsr_rep", d, 8'h02);
    cs_high();
    one_cmd(8'h04);
    check("wrdi_wel", wel, 0);
    cs_low();
    send(8'h05);
    xfer(8'h00, d, oe);
    check("rdsr_wel0", d, 8'h00);
    cs_high();
    cs_low();
    send(8'h9F);
    xfer(8'h00, d, oe);
    check("unk_miso", d, 8'h00);
    check("unk_oe", oe, 0);
    cs_high();

    // Aborted write: partial byte discarded, wel kept.
    one_cmd(8'h06);
    cs_low();
    hdr(8'h02, 24'h000003);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      #40;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
    cs_high();
    check("abort_busy", busy, 0);
    check("abort_wel", wel, 1);
    cs_low();
    hdr(8'h03, 24'h000003);
    xfer(8'h00, d, oe);
    check("abort_mem", d, 8'hA5);
    cs_high();

    // Reset in the middle of a read.
    cs_low();
    hdr(8'h03, 24'h000004);
    xfer(8'h00, d, oe);
    check("pre_rst_rd", d, 8'h3C);
    reset = 1'b1;
    #30;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_oe", miso_oe, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wel", wel, 0);
    reset = 1'b0;
    #80;
    check("post_rst_idle", busy, 0);
    cs_high();
    cs_low();
    hdr(8'h03, 24'h000003);
    xfer(8'h00, d, oe);
    check("clr_b3", d, 8'h00);
    xfer(8'h00, d, oe);
    check("clr_b4", d, 8'h00);
    cs_high();
    cs_low();
    hdr(8'h03, 24'h00000F);
    xfer(8'h00, d, oe);
    check("clr_b15", d, 8'h00);
    check("clr_oe", oe, 1);
    cs_high();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_eeprom_responder.md
Name: spi_eeprom_responder

Overview:
- SPI responder modelling a 25xx-style serial EEPROM: the device end of the EEPROM read link driven by the controller's SPI initiator.
- Samples cs/sclk/mosi in the system clock domain and decodes READ, WRITE, WREN, WRDI and RDSR.
- Serves bytes from an internal register-file memory on miso.
- Used as an on-chip bench/loopback target and as a stand-in EEPROM for bring-up.

Parameters:
- MEM_DEPTH, 16: memory size in bytes; power of two, 2..256.
- ADDR_BYTES, 3: address bytes following READ/WRITE opcodes; 1..3.

Ports:
- clk  input  1  system clock; must be at least 4x sclk frequency.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select, active low, asynchronous to clk.
- sclk  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first; 0 when not driving.
- miso_oe  output  1  high while the responder is driving data (READ_DATA/RDSR).
- wel  output  1  write-enable latch (status bit 1).
- busy  output  1  high from cs falling edge until cs rising edge is detected.

Behaviour:
- Input synchronisation:
  - cs, sclk and mosi each pass through a 2-flop synchroniser; edge detection compares the second and third flops.
  - Input-to-action latency is 3 clk for every decode, shift and state change.
- Reset: synchronous; takes priority over everything.
  - Outputs: miso=0, miso_oe=0, wel=0, busy=0.
  - State: IDLE; bit/byte counters 0.
  - Every memory byte is cleared to 0x00.
  - Reset while cs is low aborts the transaction; the responder stays IDLE until the next cs falling edge.
- Framing:
  - Detected cs fall: state=CMD, bit counter=0, busy=1.
  - Detected cs rise, from any state: state=IDLE, busy=0, miso_oe=0, miso=0. A partial byte is discarded and no memory write occurs.
- Bit timing (mode 0):
  - mosi is shifted in on a detected sclk rise.
  - miso is updated on a detected sclk fall.
  - The first output bit of a response is presented on the sclk fall that ends the last command/address bit.
- States:
  - IDLE: wait for cs fall.
  - CMD: collect 8 bits, then decode the opcode:
    - 0x03 READ -> ADDR
    - 0x02 WRITE -> ADDR if wel=1, else IGNORE
    - 0x06 WREN -> wel=1, then IGNORE
    - 0x04 WRDI -> wel=0, then IGNORE
    - 0x05 RDSR -> RDSR
    - any other opcode -> IGNORE
  - ADDR: collect ADDR_BYTES bytes MSB first; address = low log2(MEM_DEPTH) bits of the accumulated value (upper bits ignored). Then go to READ_DATA or WRITE_DATA.
  - READ_DATA:
    - miso_oe=1; output mem[addr] MSB first.
    - After each 8th sclk fall, addr=(addr+1) mod MEM_DEPTH and load the next byte.
    - Streams indefinitely; wraps from MEM_DEPTH-1 to 0.
  - WRITE_DATA:
    - On each completed 8th bit, mem[addr]=byte and addr=(addr+1) mod MEM_DEPTH.
    - On cs rise, wel is cleared only if at least one byte was written.
  - RDSR: output the status byte {6'b0, wel, 1'b0}, repeated while clocked.
  - IGNORE: consume clocks; miso=0, miso_oe=0; leave on cs rise.
- WREN/WRDI take effect 3 clk after the 8th sclk rise of the opcode, not at cs rise.
- sclk edges seen while cs is high are ignored.
- If a cs rise and an sclk edge are detected in the same clk, the cs rise wins.
- No page boundary and no write-cycle busy time: a written byte is readable in the next transaction.

Test Plan:
- Reset, then READ (0x03, addr 00 00 00), clock 2 bytes -> miso returns 0x00 0x00; miso_oe=1 during data; busy falls 3 clk after cs rise.
- WRITE without WREN (0x02, addr 0x000005, data 0x5A), then READ addr 5 -> returns 0x00; wel stays 0.
- WREN, then WRITE addr 0x000003 data 0xA5 0x3C, then RDSR -> during WRITE wel=1; after WRITE cs rise wel=0 and status byte reads 0x00; a subsequent READ addr 3 returns 0xA5 0x3C.
- Write 0x11 at addr 15 and 0x22 at addr 0 (MEM_DEPTH=16), then READ from 0x00000F for 2 bytes -> 0x11 then 0x22 (wrap-around); address 0x0000FF aliases to 15.
- WREN then RDSR -> 0x02; WRDI then RDSR -> 0x00; unknown opcode 0x9F -> miso stays 0 and miso_oe stays 0.
- Raise cs after 5 data bits of a WREN-enabled WRITE -> memory unchanged and state IDLE; assert reset mid-READ -> miso=0, all memory 0x00, next READ works normally.
